// File: rtl/vga_line_fetch.sv
// Scanline fill controller: fetches a 64-word line over a req/ack port into the VGA line buffer.
// Optional macro VGA_LINE_CACHE_EN skips the refetch of the last completely fetched line.
module vga_line_fetch #(
    parameter int unsigned             ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0,
    parameter int unsigned             LINES      = 192
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line_start,
    input  logic [7:0]            line_num,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_data,
    output logic                  bram_wr_en,
    output logic [5:0]            bram_wr_addr,
    output logic [31:0]           bram_wr_data
);

    typedef enum logic [2:0] {StIdle, StReq, StLast, StDone, StHit} state_e;

    state_e      state_q, state_d;
    logic [7:0]  line_q, line_d;
    logic [5:0]  word_q, word_d;
    logic        overrun_q, overrun_d;
    logic        wr_en_q, wr_en_d;
    logic [5:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic line_ok;
    logic idle;
    logic abort;
    logic fetch_start;
    logic fetch_end;
    logic cache_hit;

    assign line_ok = (32'(line_num) < LINES);
    // The cache-hit cycle does not count as busy, so a line_start there is a fresh request.
    assign idle    = (state_q == StIdle) || (state_q == StHit);
    assign abort   = line_start && !idle;

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        word_d      = word_q;
        overrun_d   = overrun_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        fetch_start = 1'b0;
        fetch_end   = 1'b0;

        if (abort) begin
            overrun_d   = 1'b1;
            fetch_start = line_ok;
            state_d     = line_ok ? StReq : StIdle;
        end else if (line_start && line_ok) begin
            if (cache_hit) begin
                state_d = StHit;
            end else begin
                fetch_start = 1'b1;
                state_d     = StReq;
            end
        end else begin
            case (state_q)
                StReq: begin
                    if (mem_ack) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = word_q;
                        wr_data_d = mem_data;
                        if (word_q == 6'd63) begin
                            state_d = StLast;
                        end else begin
                            word_d = word_q + 6'd1;
                        end
                    end
                end
                StLast: begin
                    fetch_end = 1'b1;
                    state_d   = StDone;
                end
                StDone, StHit: state_d = StIdle;
                default: ;
            endcase
        end

        if (fetch_start) begin
            line_d = line_num;
            word_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            line_q    <= '0;
            word_q    <= '0;
            overrun_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            word_q    <= word_d;
            overrun_q <= overrun_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef VGA_LINE_CACHE_EN
    logic       cache_valid_q, cache_valid_d;
    logic [7:0] cache_line_q, cache_line_d;

    assign cache_hit = cache_valid_q && (cache_line_q == line_num);

    // Any fetch start overwrites the line buffer, so the remembered line is lost.
    always_comb begin
        cache_valid_d = cache_valid_q;
        cache_line_d  = cache_line_q;
        if (abort || fetch_start) begin
            cache_valid_d = 1'b0;
        end else if (fetch_end) begin
            cache_valid_d = 1'b1;
            cache_line_d  = line_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid_q <= 1'b0;
            cache_line_q  <= '0;
        end else begin
            cache_valid_q <= cache_valid_d;
            cache_line_q  <= cache_line_d;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        mem_addr = '0;
        if (state_q == StReq) begin
            mem_addr = BASE_ADDR + ADDR_WIDTH'({line_q, 8'h00}) + ADDR_WIDTH'({word_q, 2'b00});
        end
    end

    assign mem_req      = (state_q == StReq);
    assign busy         = (state_q == StReq) || (state_q == StLast) || (state_q == StDone);
    assign done         = (state_q == StDone) || (state_q == StHit);
    assign overrun      = overrun_q;
    assign bram_wr_en   = wr_en_q;
    assign bram_wr_addr = wr_addr_q;
    assign bram_wr_data = wr_data_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Randomized bench for vga_line_fetch: cycle-level reference model plus directed literal checks.
module tb_vga_line_fetch;

    localparam int BASE  = 'h4000;
    localparam int LINES = 192;
`ifdef VGA_LINE_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line_start = 1'b0;
    logic [7:0]  line_num = '0;
    logic        busy, done, overrun, mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = '0;
    logic        bram_wr_en;
    logic [5:0]  bram_wr_addr;
    logic [31:0] bram_wr_data;

    vga_line_fetch #(
        .ADDR_WIDTH (16),
        .BASE_ADDR  (16'h4000),
        .LINES      (192)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .line_start   (line_start),
        .line_num     (line_num),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .bram_wr_en   (bram_wr_en),
        .bram_wr_addr (bram_wr_addr),
        .bram_wr_data (bram_wr_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [15:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    function automatic logic [15:0] exp_addr(input int line, input int w);
        int a;
        a = (BASE + line * 256 + w * 4) % 65536;
        return a[15:0];
    endfunction

    // Memory responder: 0 random ack, 1 ack every cycle, 2 ack on third cycle of each request.
    int   ack_mode = 0;
    int   lat = 0;
    logic a_nxt;
    always @(posedge clk) begin
        #1;
        a_nxt = 1'b0;
        case (ack_mode)
            0: a_nxt = mem_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            1: a_nxt = 1'b1;
            default: begin
                if (mem_req) begin
                    if (lat == 2) begin
                        a_nxt = 1'b1;
                        lat   = 0;
                    end else begin
                        lat++;
                    end
                end else begin
                    lat = 0;
                end
            end
        endcase
        mem_ack  = a_nxt;
        mem_data = a_nxt ? memfn(mem_addr) : $urandom;
    end

    // Reference model: what each output must be in the current cycle.
    bit          m_busy, m_req, m_wr, m_done, m_ovr, m_valid;
    int          m_line, m_w, m_cline;
    logic [5:0]  m_wa;
    logic [31:0] m_wd;
    bit          ok, nwr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_req = 0; m_wr = 0; m_done = 0; m_ovr = 0; m_valid = 0;
            m_line = 0; m_w = 0; m_cline = 0; m_wa = '0; m_wd = '0;
        end else begin
            ok  = line_start && (int'(line_num) < LINES);
            nwr = 0;
            if (line_start && m_busy) begin
                m_ovr = 1; m_valid = 0; m_done = 0;
                m_busy = ok; m_req = ok; m_line = int'(line_num); m_w = 0;
            end else if (ok && CACHE && m_valid && int'(line_num) == m_cline) begin
                m_done = 1;
            end else if (ok) begin
                m_valid = 0; m_done = 0; m_busy = 1; m_req = 1;
                m_line = int'(line_num); m_w = 0;
            end else if (m_done) begin
                m_done = 0; m_busy = 0;
            end else if (m_busy && m_req) begin
                if (mem_ack) begin
                    nwr = 1;
                    m_wa = 6'(m_w);
                    m_wd = memfn(exp_addr(m_line, m_w));
                    if (m_w == 63) m_req = 0;
                    else m_w++;
                end
            end else if (m_busy) begin
                m_done = 1; m_valid = 1; m_cline = m_line;
            end
            m_wr = nwr;
        end
    end

    int          wr_cnt = 0, done_cnt = 0, req_cnt = 0;
    bit          cap_first = 0;
    logic [15:0] first_addr = '0, last_addr = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("mem_req", 32'(mem_req), 32'(m_req));
            check("mem_addr", 32'(mem_addr), m_req ? 32'(exp_addr(m_line, m_w)) : 32'h0);
            check("wr_en", 32'(bram_wr_en), 32'(m_wr));
            if (m_wr) begin
                check("wr_addr", 32'(bram_wr_addr), 32'(m_wa));
                check("wr_data", bram_wr_data, m_wd);
            end
            check("done", 32'(done), 32'(m_done));
            check("overrun", 32'(overrun), 32'(m_ovr));
            if (bram_wr_en) wr_cnt++;
            if (done) done_cnt++;
            if (mem_req) begin
                req_cnt++;
                last_addr = mem_addr;
                if (cap_first) begin
                    first_addr = mem_addr;
                    cap_first  = 0;
                end
            end
        end
    end

    task automatic pulse_line(input int n);
        @(posedge clk); #1;
        line_start = 1'b1;
        line_num   = 8'(n);
        @(posedge clk); #1;
        line_start = 1'b0;
        line_num   = 8'($urandom);
    endtask

    task automatic clear_counts();
        wr_cnt = 0; done_cnt = 0; req_cnt = 0; cap_first = 1;
    endtask

    // Called in cycle 1 after a pulse; returns the cycle index in which done is seen.
    task automatic wait_done(input int budget, output int k);
        k = 1;
        while (done !== 1'b1 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_within_budget", 32'(done), 32'h1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_mem_req"}, 32'(mem_req), 32'h0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        check({tag, "_wr_en"}, 32'(bram_wr_en), 32'h0);
        check({tag, "_wr_addr"}, 32'(bram_wr_addr), 32'h0);
        check({tag, "_wr_data"}, bram_wr_data, 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_overrun"}, 32'(overrun), 32'h0);
    endtask

    int k, k2, guard, prev_line;

    initial begin
        #2;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Ack every cycle, line 0: writes in cycles 2..65, done in cycle 66.
        ack_mode = 1;
        pulse_line(0);
        clear_counts();
        wait_done(200, k);
        check("t3_done_cycle", 32'(k), 32'd66);
        check("t3_writes", 32'(wr_cnt), 32'd64);

        // Latency-2 acks, line 5 at base 0x4000.
        ack_mode = 2;
        pulse_line(5);
        clear_counts();
        wait_done(1000, k);
        check("t2_first_addr", 32'(first_addr), 32'h4500);
        check("t2_last_addr", 32'(last_addr), 32'h45FC);
        check("t2_writes", 32'(wr_cnt), 32'd64);
        check("t2_overrun", 32'(overrun), 32'h0);

        // Abort line 3 after 10 words with line 4.
        ack_mode = 0;
        pulse_line(3);
        clear_counts();
        guard = 0;
        while (wr_cnt < 10 && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("t4_ten_words", 32'(wr_cnt >= 10), 32'h1);
        pulse_line(4);
        clear_counts();
        check("t4_overrun", 32'(overrun), 32'h1);
        wait_done(2000, k);
        repeat (5) @(posedge clk);
        #1;
        check("t4_first_addr", 32'(first_addr), 32'h4400);
        check("t4_writes", 32'(wr_cnt), 32'd64);
        check("t4_single_done", 32'(done_cnt), 32'd1);

        // Async reset in the middle of a fetch.
        pulse_line(9);
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        pulse_line(0);
        clear_counts();
        wait_done(2000, k);
        check("t1_writes", 32'(wr_cnt), 32'd64);
        check("t1_overrun", 32'(overrun), 32'h0);

        // Out-of-range line is ignored.
        repeat (3) @(posedge clk);
        pulse_line(192);
        clear_counts();
        repeat (6) @(posedge clk);
        #1;
        check("t5_reqs", 32'(req_cnt), 32'd0);
        check("t5_dones", 32'(done_cnt), 32'd0);
        check("t5_busy", 32'(busy), 32'h0);

        // Same line twice.
        ack_mode = 1;
        pulse_line(7);
        clear_counts();
        wait_done(200, k);
        pulse_line(7);
        wait_done(200, k2);
        check("t6_second_done_cycle", 32'(k2), CACHE ? 32'd1 : 32'd66);
        check("t6_writes", 32'(wr_cnt), CACHE ? 32'd64 : 32'd128);

        // Random line starts, random ack behaviour, some out of range, some repeats.
        prev_line = 7;
        for (int i = 0; i < 40; i++) begin
            ack_mode = $urandom_range(0, 2);
            repeat ($urandom_range(0, 90)) @(posedge clk);
            if ($urandom_range(0, 3) == 0) pulse_line(prev_line);
            else begin
                prev_line = ($urandom_range(0, 4) == 0) ? $urandom_range(180, 255)
                                                        : $urandom_range(0, 191);
                pulse_line(prev_line);
            end
        end
        repeat (300) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
